// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a TX FIFO, STATUS reports FIFO/FSM/overflow state.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] RD,
  output logic        Hit,
  output logic        tx,
  output logic        Busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartStateT;

  uartStateT     state;
  logic [7:0]    shiftReg;
  logic [2:0]    bitCnt;
  logic [BW-1:0] baudCnt;
  logic [PW:0]   wrPtr, rdPtr;
  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic          ovf;

  logic full, empty, txWrite, push, overflow, ovfClr, pop;
  logic [31:0] status;
  logic unusedBits;

  assign Hit      = (DataAddr[31:3] == BASE_ADDR[31:3]);
  assign full     = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign empty    = (wrPtr == rdPtr);
  assign txWrite  = MemWrite & Hit & ~DataAddr[2];
  assign push     = txWrite & ~full;
  assign overflow = txWrite & full;
  assign ovfClr   = MemWrite & Hit & DataAddr[2] & WriteData[3];
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & (baudCnt == '0)));

  assign status = {28'd0, ovf, (state != IDLE), empty, full};
  assign RD     = (Hit & DataAddr[2]) ? status : '0;
  assign Busy   = ~empty | (state != IDLE);

  assign unusedBits = ^{DataAddr[1:0], WriteData[31:8]};

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr[PW-1:0]] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + (PW+1)'(1);
      // Overflow set takes priority over a same-edge software clear
      if (overflow)    ovf <= 1'b1;
      else if (ovfClr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shiftReg <= '0;
      bitCnt   <= '0;
      baudCnt  <= '0;
      rdPtr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shiftReg <= fifoMem[rdPtr[PW-1:0]];
            rdPtr    <= rdPtr + (PW+1)'(1);
            bitCnt   <= '0;
            baudCnt  <= BAUD_MAX;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baudCnt == '0) begin
            baudCnt <= BAUD_MAX;
            tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
        DATA: begin
          if (baudCnt == '0) begin
            baudCnt <= BAUD_MAX;
            if (bitCnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // tx is registered, so it takes the bit that becomes shiftReg[0] after this shift
              shiftReg <= shiftReg >> 1;
              tx       <= shiftReg[1];
              bitCnt   <= bitCnt + 3'd1;
            end
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
        STOP: begin
          if (baudCnt == '0) begin
            if (pop) begin
              shiftReg <= fifoMem[rdPtr[PW-1:0]];
              rdPtr    <= rdPtr + (PW+1)'(1);
              bitCnt   <= '0;
              baudCnt  <= BAUD_MAX;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: frame timing and STATUS derived from an edge-arithmetic model of FIFO and transmitter.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAddr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] RD;
  logic        Hit, tx, Busy;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAddr(DataAddr),
    .WriteData(WriteData), .RD(RD), .Hit(Hit), .tx(tx), .Busy(Busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    longint     popEdge;
  } frameT;

  frameT  sbQ[$];
  longint pushEdges[$];
  longint popEdges[$];
  longint lastPop = -1000;
  logic   ovfM = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bytes held in the FIFO after edge t: accepted pushes minus pops up to t
  function automatic int countAfter(input longint t);
    int n = 0;
    foreach (pushEdges[i]) if (pushEdges[i] <= t) n++;
    foreach (popEdges[i])  if (popEdges[i] <= t) n--;
    return n;
  endfunction

  function automatic logic fsmBusy(input longint t);
    foreach (popEdges[i]) if (popEdges[i] <= t && t < popEdges[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] statusM(input longint t);
    int n;
    n = countAfter(t);
    return {28'd0, ovfM, fsmBusy(t), (n == 0), (n == DEPTH)};
  endfunction

  task automatic modelApply(input logic we, input logic [31:0] a, input logic [31:0] d,
                            input longint t, input logic fc);
    logic   hit;
    longint p;
    frameT  f;
    hit = (a[31:3] == BASE[31:3]);
    if ((we && hit && a[2] && d[3]) || fc) ovfM = 1'b0;
    if (we && hit && !a[2]) begin
      if (countAfter(t - 1) == DEPTH) ovfM = 1'b1;
      else begin
        p = (t + 1 > lastPop + FRAME) ? t + 1 : lastPop + FRAME;
        pushEdges.push_back(t);
        popEdges.push_back(p);
        lastPop = p;
        f.data = d[7:0];
        f.popEdge = p;
        sbQ.push_back(f);
      end
    end
  endtask

  task automatic clearModel();
    sbQ.delete();
    pushEdges.delete();
    popEdges.delete();
    lastPop = -1000;
    ovfM = 1'b0;
  endtask

  // Drive one bus cycle ahead of the next rising edge and check combinational outputs
  task automatic busCycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic fc = 1'b0);
    logic   expHit;
    longint t;
    @(negedge clk);
    MemWrite = we;
    DataAddr = a;
    WriteData = d;
    if (fc) force dut.ovfClr = 1'b1;
    #1;
    t = cyc;
    expHit = (a[31:3] == BASE[31:3]);
    check("hit", {31'd0, Hit}, {31'd0, expHit});
    if (!we) check("rd", RD, (expHit && a[2]) ? statusM(t) : 32'd0);
    check("busy", {31'd0, Busy}, {31'd0, (countAfter(t) > 0) || fsmBusy(t)});
    modelApply(we, a, d, t + 1, fc);
  endtask

  task automatic readStatus(input int n);
    repeat (n) busCycle(1'b0, BASE + 32'd4, 32'd0);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && sbQ.size() > 0; i++) readStatus(1);
    check("drain_pending", sbQ.size(), 0);
    readStatus(FRAME);
  endtask

  // Monitor: decodes frames off tx and retires scoreboard entries
  logic       monInFrame = 1'b0;
  longint     monStart = 0;
  logic [9:0] monBits = '0;

  initial begin
    longint off;
    int k;
    forever begin
      @(negedge clk);
      if (reset) begin
        monInFrame = 1'b0;
        continue;
      end
      if (!monInFrame) begin
        if (tx === 1'b0) begin
          if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_frame: start bit with nothing queued (cycle %0d)", cyc);
          end else begin
            check("start_edge", 32'(cyc), 32'(sbQ[0].popEdge));
          end
          monInFrame = 1'b1;
          monStart = cyc;
        end
      end else begin
        off = cyc - monStart;
        if (off % CPB == CPB / 2) begin
          k = int'(off / CPB);
          monBits[k] = tx;
          if (k == 9) begin
            check("stop_bit", {31'd0, monBits[9]}, 32'd1);
            if (sbQ.size() > 0) begin
              check("tx_byte", {24'd0, monBits[8:1]}, {24'd0, sbQ[0].data});
              void'(sbQ.pop_front());
            end
            monInFrame = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int cnt;
    longint target;
    logic [31:0] a;

    @(negedge clk);
    DataAddr = BASE + 32'd4;
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_status", RD, 32'h2);
    @(negedge clk);
    reset = 1'b0;
    readStatus(2);

    // Single frame, latency and Busy length
    busCycle(1'b1, BASE, 32'hFFFF_FFA5);
    cnt = 0;
    repeat (60) begin
      busCycle(1'b0, BASE + 32'd4, 32'd0);
      if (Busy) cnt++;
    end
    check("busy_len", cnt, 41);
    drain(200);

    // Back-to-back frames
    busCycle(1'b1, BASE, 32'h01);
    busCycle(1'b1, BASE, 32'h02);
    busCycle(1'b1, BASE, 32'h03);
    drain(400);

    // Overflow burst, then clear
    for (int i = 0; i < 10; i++) busCycle(1'b1, BASE, 32'h10 + 32'(i));
    readStatus(1);
    check("ovf_after_burst", {31'd0, RD[3]}, 32'd1);
    drain(1000);
    busCycle(1'b1, BASE + 32'd4, 32'h8);
    readStatus(1);
    check("ovf_cleared", {31'd0, RD[3]}, 32'd0);

    // Decode corners
    busCycle(1'b0, BASE + 32'd4, 32'd0);
    busCycle(1'b0, BASE + 32'd8, 32'd0);
    busCycle(1'b1, BASE + 32'd12, 32'h55);
    busCycle(1'b0, BASE, 32'd0);
    busCycle(1'b0, BASE + 32'd7, 32'd0);
    readStatus(3);

    // Reset during DATA of the second queued frame
    busCycle(1'b1, BASE, 32'h00);
    busCycle(1'b1, BASE, 32'h00);
    target = popEdges[popEdges.size() - 1] + 3 * CPB;
    for (int i = 0; i < 200 && cyc < target; i++) readStatus(1);
    @(negedge clk);
    MemWrite = 1'b0;
    #1;
    check("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    #1;
    check("async_reset_tx", {31'd0, tx}, 32'd1);
    clearModel();
    @(negedge clk);
    reset = 1'b0;
    readStatus(1);
    check("status_after_reset", RD, 32'h2);
    readStatus(FRAME + 20);

    // Overflow set wins over a same-edge clear
    for (int i = 0; i < 9; i++) busCycle(1'b1, BASE, 32'h60 + 32'(i));
    busCycle(1'b1, BASE, 32'h6F, 1'b1);
    @(posedge clk);
    #1;
    release dut.ovfClr;
    readStatus(1);
    check("ovf_set_wins", {31'd0, RD[3]}, 32'd1);
    drain(1000);
    busCycle(1'b1, BASE + 32'd4, 32'hFFFF_FFFF);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: busCycle(1'b1, BASE + 32'($urandom_range(0, 3)), $urandom);
        3:       busCycle(1'b1, BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom);
        4: begin
          a = $urandom;
          busCycle(1'b1, a, $urandom);
        end
        5: begin
          a = $urandom;
          busCycle(1'b0, a, 32'd0);
        end
        default: readStatus($urandom_range(1, 8));
      endcase
    end
    drain(8000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
